// File: rtl/dbf_pkg.sv
// Shared state encoding and fixed-point helpers for the dynamic-focus beamforming channel.
package dbf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFETCH = 2'd1,
      ST_RUN      = 2'd2
   } dbf_state_e;

   function automatic longint pow2(input int n);
      return longint'(1) << n;
   endfunction

   function automatic longint rnd_const(input int shift);
      return (shift > 0) ? pow2(shift - 1) : longint'(0);
   endfunction

   function automatic longint sat_hi(input int w);
      return pow2(w - 1) - longint'(1);
   endfunction

   function automatic longint sat_lo(input int w);
      return -pow2(w - 1);
   endfunction

endpackage

// File: rtl/dbf_delay_ram.sv
// Simple dual-port RAM with registered read; a same-address write returns the new data.
module dbf_delay_ram #(
   parameter int WD = 14,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WD-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [WD-1:0] rdata
);

   logic [WD-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

endmodule

// File: rtl/dbf_ch_dynfocus.sv
// Beamforming channel: circular delay buffer with per-zone coarse delay, apodization and round/saturate.
// state    | meaning
// IDLE     | LUT writable; pointers, sample count and zone held at zero
// PREFETCH | two cycles loading LUT[0] into dly_cur and LUT[1] into dly_nxt
// RUN      | accepting samples; delay advances at each zone boundary
module dbf_ch_dynfocus
   import dbf_pkg::*;
#(
   parameter int INPUT_WD  = 14,
   parameter int APO_WD    = 16,
   parameter int OUT_WD    = 16,
   parameter int SHIFT     = 15,
   parameter int DLY_WD    = 8,
   parameter int BUF_DEPTH = 128,
   parameter int LUT_AW    = 6,
   parameter int ZONE_LEN  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [INPUT_WD-1:0] din,
   input  logic                din_valid,
   input  logic [APO_WD-1:0]   apo_din,
   input  logic                apo_en,
   input  logic [LUT_AW-1:0]   lut_addr,
   input  logic [DLY_WD-1:0]   lut_wdata,
   input  logic                lut_we,
   output logic                ready,
   output logic [INPUT_WD-1:0] cd_dout,
   output logic [OUT_WD-1:0]   dout,
   output logic                dout_valid,
   output logic                err_ovf,
   output logic                err_sat
);

   localparam int AW  = $clog2(BUF_DEPTH);
   localparam int AW1 = AW + 1;
   localparam int ZW  = $clog2(ZONE_LEN);
   localparam int LW1 = LUT_AW + 1;
   localparam int WW  = APO_WD + 1;
   localparam int PW1 = INPUT_WD + APO_WD + 1;

   localparam logic [LUT_AW-1:0]  ZMAX    = '1;
   localparam logic [DLY_WD-1:0]  DLY_MAX = DLY_WD'(BUF_DEPTH - 1);
   localparam logic [ZW-1:0]      ZLOAD   = ZW'(ZONE_LEN - 1);
   // Weight carries one extra bit so unity (1<<SHIFT) is representable.
   localparam logic signed [WW-1:0]  UNITY = WW'(pow2(SHIFT));
   localparam logic signed [PW1-1:0] RND   = PW1'(rnd_const(SHIFT));
   localparam logic signed [PW1-1:0] OHI   = PW1'(sat_hi(OUT_WD));
   localparam logic signed [PW1-1:0] OLO   = PW1'(sat_lo(OUT_WD));

   dbf_state_e state;
   logic                     start_q;
   logic                     pf_first;
   logic                     nxt_pend;
   logic [AW-1:0]            wr_ptr;
   logic [AW1-1:0]           n_cnt;
   logic [LUT_AW-1:0]        zone_idx;
   logic [ZW-1:0]            zcnt;
   logic [AW-1:0]            dly_cur;
   logic [AW-1:0]            dly_nxt;
   logic                     zero_q;
   logic signed [WW-1:0]     wgt_q;
   logic                     v1;
   logic                     v2;
   logic signed [PW1-1:0]    prod;

   logic                     accept;
   logic [LW1-1:0]           zone_ahead;
   logic [LUT_AW-1:0]        lut_raddr;
   logic [DLY_WD-1:0]        lut_rdata;
   logic                     fetch_ovf;
   logic [AW-1:0]            fetch_dly;
   logic [AW-1:0]            buf_raddr;
   logic [INPUT_WD-1:0]      buf_rdata;
   logic signed [INPUT_WD-1:0] delayed;
   logic signed [PW1-1:0]    rounded;
   logic signed [PW1-1:0]    shifted;

   assign accept     = ready && start && din_valid;
   assign zone_ahead = {1'b0, zone_idx} + LW1'(2);
   assign fetch_ovf  = lut_rdata > DLY_MAX;
   assign fetch_dly  = fetch_ovf ? AW'(BUF_DEPTH - 1) : lut_rdata[AW-1:0];
   assign buf_raddr  = wr_ptr - dly_cur;
   assign delayed    = zero_q ? '0 : $signed(buf_rdata);
   assign cd_dout    = delayed;
   assign rounded    = prod + RND;
   assign shifted    = rounded >>> SHIFT;

   // Issue the LUT read for the zone after next at a zone boundary so dly_nxt refills in one cycle.
   always_comb begin
      lut_raddr = '0;
      case (state)
         ST_PREFETCH: lut_raddr = LUT_AW'(1);
         ST_RUN:      lut_raddr = (zone_ahead > {1'b0, ZMAX}) ? ZMAX : zone_ahead[LUT_AW-1:0];
         default:     lut_raddr = '0;
      endcase
   end

   dbf_delay_ram #(.WD(DLY_WD), .AW(LUT_AW)) u_lut (
      .clk   (clk),
      .rst   (rst),
      .we    (lut_we && !start),
      .waddr (lut_addr),
      .wdata (lut_wdata),
      .re    (1'b1),
      .raddr (lut_raddr),
      .rdata (lut_rdata)
   );

   dbf_delay_ram #(.WD(INPUT_WD), .AW(AW)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (accept),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         start_q    <= 1'b1;
         pf_first   <= 1'b0;
         nxt_pend   <= 1'b0;
         wr_ptr     <= '0;
         n_cnt      <= '0;
         zone_idx   <= '0;
         zcnt       <= ZLOAD;
         dly_cur    <= '0;
         dly_nxt    <= '0;
         zero_q     <= 1'b1;
         wgt_q      <= '0;
         v1         <= 1'b0;
         v2         <= 1'b0;
         prod       <= '0;
         ready      <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         err_ovf    <= 1'b0;
         err_sat    <= 1'b0;
      end else begin
         start_q <= start;
         if (lut_we && start) err_ovf <= 1'b1;
         if (!start) begin
            state      <= ST_IDLE;
            ready      <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            dout_valid <= 1'b0;
            pf_first   <= 1'b0;
            nxt_pend   <= 1'b0;
            wr_ptr     <= '0;
            n_cnt      <= '0;
            zone_idx   <= '0;
            zcnt       <= ZLOAD;
            zero_q     <= 1'b1;
         end else begin
            v1         <= accept;
            v2         <= v1;
            dout_valid <= v2;
            if (v1) prod <= PW1'(delayed) * PW1'(wgt_q);
            if (v2) begin
               if (shifted > OHI) begin
                  dout    <= OUT_WD'(OHI);
                  err_sat <= 1'b1;
               end else if (shifted < OLO) begin
                  dout    <= OUT_WD'(OLO);
                  err_sat <= 1'b1;
               end else begin
                  dout <= shifted[OUT_WD-1:0];
               end
            end
            case (state)
               ST_IDLE: begin
                  // Only a genuine rising edge starts a run, so a start held through rst does not.
                  if (!start_q) begin
                     state    <= ST_PREFETCH;
                     pf_first <= 1'b1;
                  end
               end
               ST_PREFETCH: begin
                  if (fetch_ovf) err_ovf <= 1'b1;
                  if (pf_first) begin
                     dly_cur  <= fetch_dly;
                     pf_first <= 1'b0;
                  end else begin
                     dly_nxt <= fetch_dly;
                     state   <= ST_RUN;
                     ready   <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (nxt_pend) begin
                     dly_nxt  <= fetch_dly;
                     nxt_pend <= 1'b0;
                     if (fetch_ovf) err_ovf <= 1'b1;
                  end
                  if (accept) begin
                     wr_ptr <= wr_ptr + AW'(1);
                     if (!n_cnt[AW]) n_cnt <= n_cnt + AW1'(1);
                     zero_q <= n_cnt < {1'b0, dly_cur};
                     wgt_q  <= apo_en ? WW'($signed(apo_din)) : UNITY;
                     if (zcnt == '0) begin
                        zcnt     <= ZLOAD;
                        dly_cur  <= dly_nxt;
                        zone_idx <= (zone_idx == ZMAX) ? ZMAX : zone_idx + LUT_AW'(1);
                        nxt_pend <= 1'b1;
                     end else begin
                        zcnt <= zcnt - ZW'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/dbf_ch_dynfocus.md
# dbf_ch_dynfocus

Parametrised digital-beamforming channel with dynamic receive focusing. Writes each received echo sample into a circular delay buffer, reads it back with a coarse delay that changes per focal zone, applies a signed apodization weight, then rounds and saturates the result. One instance per array element sits between the ADC sample path and the channel summation tree. It generalises the fixed-width single-delay channel with programmable width, buffer depth, zone-indexed delay LUT, an apodization bypass mode, and overflow/saturation flags.

## Interface
- INPUT_WD, 14, signed input sample width
- APO_WD, 16, signed apodization weight width
- OUT_WD, 16, signed output width
- SHIFT, 15, right shift applied to the product (weight scaling Q1.SHIFT)
- DLY_WD, 8, width of a stored coarse-delay entry
- BUF_DEPTH, 128, delay buffer depth (power of two); maximum usable delay is BUF_DEPTH-1
- LUT_AW, 6, delay LUT address width; LUT_DEPTH = 2**LUT_AW zones
- ZONE_LEN, 16, accepted samples per focal zone; must be ≥ 2
- clk  in  1  system clock (40 MHz)
- rst  in  1  asynchronous active-high reset
- start  in  1  level; high = beamforming active
- din  in  INPUT_WD  signed echo sample
- din_valid  in  1  sample strobe (driver feeds ~tx_en)
- apo_din  in  APO_WD  signed weight, sampled with din
- apo_en  in  1  0 = unity weight (1<<SHIFT)
- lut_addr  in  LUT_AW  delay LUT write address
- lut_wdata  in  DLY_WD  delay value in samples
- lut_we  in  1  LUT write strobe
- ready  out  1  channel accepts samples
- cd_dout  out  INPUT_WD  delayed sample before weighting (debug)
- dout  out  OUT_WD  weighted output
- dout_valid  out  1  dout qualifier
- err_ovf  out  1  sticky: LUT entry exceeded BUF_DEPTH-1, or LUT written while start=1
- err_sat  out  1  sticky: output saturation occurred

## Operation
- Idle (start=0): lut_we writes LUT[lut_addr]. Pointers, sample counter and zone index are held at 0. ready=0, dout_valid=0.
- PREFETCH: on a rising edge of start, spend 2 cycles loading LUT[0] into dly_cur and LUT[1] into dly_nxt, then enter RUN with ready=1. din_valid is ignored while ready=0.
- RUN, per accepted sample n:
  - write din to buf[wr_ptr], then increment wr_ptr modulo BUF_DEPTH;
  - read address = wr_ptr − dly_cur, modulo BUF_DEPTH;
  - if n < dly_cur, the delayed sample is 0.
- Zone advance: the delay applied to sample n is LUT[min(n/ZONE_LEN, LUT_DEPTH−1)].
  - On the last sample of a zone, dly_nxt moves into dly_cur.
  - The LUT read for the following zone is then issued.
  - The zone index saturates at LUT_DEPTH−1.
- Delay clamp: any fetched entry greater than BUF_DEPTH−1 is used as BUF_DEPTH−1 and sets err_ovf.
- Arithmetic:
  - product = delayed × weight, INPUT_WD+APO_WD bits signed;
  - add 1<<(SHIFT−1), then arithmetic shift right by SHIFT;
  - saturate to [−2^(OUT_WD−1), 2^(OUT_WD−1)−1]; on clip set err_sat.
- lut_we while start=1 is ignored and sets err_ovf.
- start falling: return to idle on the next cycle. In-flight pipeline data is discarded and dout_valid drops immediately. Sticky flags clear only on rst.

## Timing
- Reset values: ready=0, dout=0, dout_valid=0, cd_dout=0, err_ovf=0, err_sat=0. Pointers, counters, dly_cur, dly_nxt and FSM go to 0/IDLE. LUT and buffer contents are undefined.
- ready rises 2 cycles after start is first sampled high.
- Latency is 3 cycles from a din_valid edge to the matching dout_valid edge: buffer read (registered) → multiply (registered) → round/saturate (registered).
- cd_dout is valid 1 cycle after acceptance.
- Back-to-back din_valid is supported at full rate. Gaps pass through as gaps in dout_valid.
- Write and read of the same buffer address in one cycle (delay 0) returns the new sample via write-first bypass.
- rst mid-stream takes effect immediately (asynchronous); the block restarts only on a new start rising edge.

## Structure
- Shared package dbf_pkg: FSM state encoding (IDLE, PREFETCH, RUN), the rounding constant function, and the saturation limit functions.
- One sub-module, dbf_delay_ram: a simple dual-port RAM with a registered read, instantiated for both the delay buffer and the LUT.
- The top level holds the FSM, pointers, zone counter, multiplier pipeline and flags.

## Test plan
- All LUT entries 0, apo_en=0, ramp din=1,2,3,… continuous → dout=1,2,3,… beginning 3 cycles after the first valid; err flags stay 0.
- LUT[0]=5, ZONE_LEN=16 → dout=0 for n=0..4, and dout[n]=din[n−5] for n≥5.
- LUT[0]=2, LUT[1]=6, ZONE_LEN=8, din=n → dout[7]=5, dout[8]=2 (zone switch at sample 8, no glitch).
- apo_en=1, apo=16384, din=−3 → dout=−1; apo=−32768, din=1 → dout=−1.
- SHIFT=8, din=8191, apo=32767 → dout=32767 with err_sat=1; din=−8192, apo=32767 → dout=−32768.
- LUT[0]=200, BUF_DEPTH=128 → effective delay 127, err_ovf=1. Separately: lut_we with start=1 leaves the LUT unchanged; rst asserted mid-RUN → all outputs reach reset values the same cycle.
